ofm_tile_addr_gen: RTL and testbench
====================================

# ofm_tile_addr_gen

Parametrised read-address generator for the OFM/IFM feature-map RAM. It feeds the systolic array's operand loader, one output row of one column tile at a time. It adds three things: stride-1/2 support, column tiling of outputs wider than the array, and a valid/ready address handshake with back-pressure. Each `load` streams the K×K×C window addresses for the current tile position, then advances the row/column tile pointers across the whole layer.

## Interface
- `SYSTOLIC_SIZE`, 16: array width; maximum columns per tile.
- `RAM_SIZE`, 2378675: feature RAM depth in words.
- `ADDR_W`, $clog2(RAM_SIZE): address width.
- `CH_W`, 11: channel-count width.
- `clk` in 1: the single clock; all logic is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: pulse; latches config and `start_read_addr`, rewinds the layer walk.
- `start_read_addr` in ADDR_W: layer base address (pixel (0,0), channel 0).
- `load` in 1: pulse; request one tile-row address burst.
- `addr_ready` in 1: consumer accepts `ofm_addr` this cycle.
- `ifm_size` in 9: input width = height, S.
- `ifm_channel` in CH_W: channel count, C ≥ 1.
- `kernel_size` in 2: K ∈ {1,2,3}; 0 is illegal.
- `stride` in 1: 0 → stride 1, 1 → stride 2.
- `ofm_size` in 9: output width = height, O; the caller guarantees O = (S−K)/stride+1.
- `ofm_addr` out ADDR_W: current read address.
- `read_en` out 1: `ofm_addr` is valid.
- `read_ofm_size` out $clog2(SYSTOLIC_SIZE)+1: valid columns in the current tile.
- `busy` out 1: high in ISSUE and DONE.
- `tile_done` out 1: one-cycle pulse after the last address of a burst is accepted.
- `layer_done` out 1: pulses together with `tile_done` on the last burst of the layer.

## Operation
- States: IDLE, ISSUE, DONE.
- IDLE → ISSUE on `load`. ISSUE → DONE when the last address handshakes. DONE → IDLE unconditionally.
- `start` in any state returns the block to IDLE next cycle. It also:
  - latches config, `plane` = S·S (18 bits), base = `start_read_addr`;
  - clears row/col counters and suppresses `tile_done`;
  - takes priority over a simultaneous `load`.
- `load` outside IDLE is ignored; there is no queueing.
- Burst order, innermost first: kx 0..K−1, ky 0..K−1, c 0..C−1.
- Burst address = `win_base` + c·plane + ky·S + kx, formed incrementally from adders only:
  - kx step: +1;
  - ky step: line pointer += S;
  - c step: channel pointer += plane.
- Burst length is K·K·C handshakes.
- `win_base` = base + row·stride·S + col·stride, where row ∈ [0,O) and col is the tile's first output column.
- `read_ofm_size` = min(SYSTOLIC_SIZE, O − col). It is updated on entry to ISSUE and held until the next entry.
- In DONE:
  - if row < O−1: row += 1, `win_base` += stride·S;
  - else: row = 0, col += SYSTOLIC_SIZE, `win_base` = base + col_new·stride.
  - If row = O−1 and col + SYSTOLIC_SIZE ≥ O, the layer is finished: assert `layer_done`, then reset row, col and `win_base` to base.
- Arithmetic is unsigned and wraps modulo 2^ADDR_W; there is no range check.

## Timing
- Reset values: `ofm_addr` 0, `read_en` 0, `read_ofm_size` 0, `busy` 0, `tile_done` 0, `layer_done` 0, state IDLE, all counters 0.
- `load` sampled in cycle t → `read_en`=1 with the first address in cycle t+1.
- A handshake is `read_en` && `addr_ready`. The next address appears the following cycle, giving 1 address/cycle at full throughput.
- While `addr_ready`=0, `ofm_addr` and `read_en` hold stable.
- The last handshake in cycle t gives: `read_en`=0, `tile_done`=1 (and `layer_done` if final) in t+1; IDLE in t+2.
- The earliest accepted next `load` is in t+2.
- `rst` mid-burst aborts the burst with no `tile_done`, and outputs take their reset values next cycle.

## Test plan
- S=5, C=1, K=3, stride 1, O=3, base 100, `addr_ready`=1 → burst 100,101,102,105,106,107,110,111,112; `read_ofm_size`=3; `tile_done` 1 cycle after 112. Second burst starts at 105; the third burst also asserts `layer_done`.
- K=1, C=4, S=4, O=4, base 0 → burst 0,16,32,48; the next burst starts at 4.
- S=7, K=3, stride 2, O=3, base 0 → second burst starts at 14, third at 28.
- SYSTOLIC_SIZE=4, S=O=6, K=1:
  - first six bursts have `read_ofm_size`=4 and row bases 0,6,…,30;
  - seventh burst has `read_ofm_size`=2, base 4;
  - `layer_done` on the 12th burst.
- Drop `addr_ready` for 3 cycles at the 2nd address of the first scenario → 101 held for 4 cycles with `read_en` high. The burst order is unchanged and `tile_done` is delayed by 3 cycles.
- Assert `start` (base 200) mid-burst → IDLE next cycle, no `tile_done`; the next `load` emits 200 first. Assert `rst` mid-burst → all outputs 0 next cycle.

Source files
------------

// File: rtl/ofm_tile_addr_gen_if.sv
// Address handshake between the tile address generator and the operand loader.
// The generator presents ofm_addr/read_en; the loader answers with addr_ready.
interface ofm_tile_addr_gen_if #(
  parameter int ADDR_W = 22
);
  logic [ADDR_W-1:0] ofm_addr;
  logic              read_en;
  logic              addr_ready;

  modport master (output ofm_addr, output read_en, input addr_ready);
  modport slave  (input ofm_addr, input read_en, output addr_ready);
endinterface

// File: rtl/ofm_tile_addr_gen.sv
// OFM/IFM read-address generator: one K x K x C window burst per load,
// walking output rows of each column tile, then the next column tile.
//
// state | meaning
// IDLE  | waiting for load
// ISSUE | presenting window addresses, one per handshake
// DONE  | burst finished, advance row/column tile pointers
module ofm_tile_addr_gen #(
  parameter int SYSTOLIC_SIZE = 16,
  parameter int RAM_SIZE      = 2378675,
  parameter int ADDR_W        = $clog2(RAM_SIZE),
  parameter int CH_W          = 11
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [ADDR_W-1:0]              start_read_addr,
  input  logic                           load,
  input  logic [8:0]                     ifm_size,
  input  logic [CH_W-1:0]                ifm_channel,
  input  logic [1:0]                     kernel_size,
  input  logic                           stride,
  input  logic [8:0]                     ofm_size,
  ofm_tile_addr_gen_if.master            rd,
  output logic [$clog2(SYSTOLIC_SIZE):0] read_ofm_size,
  output logic                           busy,
  output logic                           tile_done,
  output logic                           layer_done
);

  localparam int RO_W = $clog2(SYSTOLIC_SIZE) + 1;
  localparam logic [9:0] TILE_W = 10'(SYSTOLIC_SIZE);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t state_q, state_d;

  logic [8:0]        s_q, o_q;
  logic [CH_W-1:0]   c_q;
  logic [1:0]        k_q;
  logic              stride_q;
  logic [17:0]       plane_q;
  logic [ADDR_W-1:0] base_q;

  logic [8:0]        row_q;
  logic [9:0]        col_q;
  logic [ADDR_W-1:0] win_base_q;

  logic [1:0]        kx_q, ky_q;
  logic [CH_W-1:0]   ch_q;
  logic [ADDR_W-1:0] addr_q, line_q, chan_q;

  logic              read_en;
  logic              hs, last_kx, last_ky, last_ch, last_beat;
  logic              last_row, last_tile;
  logic [ADDR_W-1:0] s_step, plane_step, row_step, col_off;
  logic [9:0]        col_next, cols_left;

  assign s_step     = ADDR_W'(s_q);
  assign plane_step = ADDR_W'(plane_q);
  assign row_step   = stride_q ? ADDR_W'({s_q, 1'b0}) : s_step;
  assign col_next   = col_q + TILE_W;
  assign col_off    = stride_q ? ADDR_W'({col_next, 1'b0}) : ADDR_W'(col_next);
  assign cols_left  = {1'b0, o_q} - col_q;

  assign last_kx   = (kx_q == k_q - 2'd1);
  assign last_ky   = (ky_q == k_q - 2'd1);
  assign last_ch   = (ch_q == c_q - CH_W'(1));
  assign last_beat = last_kx && last_ky && last_ch;
  assign hs        = (state_q == ISSUE) && rd.addr_ready;

  assign last_row  = (row_q == o_q - 9'd1);
  // Final tile of the layer: last output row and no further column tile.
  assign last_tile = last_row && (col_next >= {1'b0, o_q});

  assign rd.ofm_addr = addr_q;
  assign rd.read_en  = read_en;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; start overrides everything, including a same-cycle load.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load) state_d = ISSUE;
      ISSUE:   if (hs && last_beat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (start) state_d = IDLE;
  end

  // State-decoded outputs.
  always_comb begin
    read_en    = 1'b0;
    busy       = 1'b0;
    tile_done  = 1'b0;
    layer_done = 1'b0;
    case (state_q)
      ISSUE: begin
        read_en = 1'b1;
        busy    = 1'b1;
      end
      DONE: begin
        busy       = 1'b1;
        tile_done  = 1'b1;
        layer_done = last_tile;
      end
      default: ;
    endcase
  end

  // Layer configuration, captured on start.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q      <= '0;
      o_q      <= '0;
      c_q      <= '0;
      k_q      <= '0;
      stride_q <= 1'b0;
      plane_q  <= '0;
      base_q   <= '0;
    end else if (start) begin
      s_q      <= ifm_size;
      o_q      <= ofm_size;
      c_q      <= ifm_channel;
      k_q      <= kernel_size;
      stride_q <= stride;
      plane_q  <= {9'd0, ifm_size} * {9'd0, ifm_size};
      base_q   <= start_read_addr;
    end
  end

  // Row/column tile walk across the layer; advances once per finished burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q      <= '0;
      col_q      <= '0;
      win_base_q <= '0;
    end else if (start) begin
      row_q      <= '0;
      col_q      <= '0;
      win_base_q <= start_read_addr;
    end else if (state_q == DONE) begin
      if (last_tile) begin
        row_q      <= '0;
        col_q      <= '0;
        win_base_q <= base_q;
      end else if (!last_row) begin
        row_q      <= row_q + 9'd1;
        win_base_q <= win_base_q + row_step;
      end else begin
        row_q      <= '0;
        col_q      <= col_next;
        win_base_q <= base_q + col_off;
      end
    end
  end

  // Window address walk: kx innermost, then ky (line pointer), then channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q        <= '0;
      line_q        <= '0;
      chan_q        <= '0;
      kx_q          <= '0;
      ky_q          <= '0;
      ch_q          <= '0;
      read_ofm_size <= '0;
    end else if (!start) begin
      if (state_q == IDLE && load) begin
        addr_q        <= win_base_q;
        line_q        <= win_base_q;
        chan_q        <= win_base_q;
        kx_q          <= '0;
        ky_q          <= '0;
        ch_q          <= '0;
        read_ofm_size <= (cols_left >= TILE_W) ? RO_W'(SYSTOLIC_SIZE) : cols_left[RO_W-1:0];
      end else if (hs) begin
        if (!last_kx) begin
          kx_q   <= kx_q + 2'd1;
          addr_q <= addr_q + ADDR_W'(1);
        end else if (!last_ky) begin
          kx_q   <= '0;
          ky_q   <= ky_q + 2'd1;
          line_q <= line_q + s_step;
          addr_q <= line_q + s_step;
        end else if (!last_ch) begin
          kx_q   <= '0;
          ky_q   <= '0;
          ch_q   <= ch_q + CH_W'(1);
          chan_q <= chan_q + plane_step;
          line_q <= chan_q + plane_step;
          addr_q <= chan_q + plane_step;
        end
      end
    end
  end

endmodule

// File: tb/tb_ofm_tile_addr_gen.sv
// Bench for ofm_tile_addr_gen: table of known bursts, hand-written corner
// sequences, and randomized layers against an arithmetic reference model.
`timescale 1ns/1ps
module tb_ofm_tile_addr_gen;
  localparam int SS       = 4;
  localparam int RAM_SIZE = 2378675;
  localparam int AW       = $clog2(RAM_SIZE);
  localparam int CW       = 11;
  localparam int RW       = $clog2(SS) + 1;
  localparam longint MASK = (longint'(1) << AW) - 1;

  logic          clk = 1'b0;
  logic          rst, start, load, stride;
  logic [AW-1:0] start_read_addr;
  logic [8:0]    ifm_size, ofm_size;
  logic [CW-1:0] ifm_channel;
  logic [1:0]    kernel_size;
  logic [RW-1:0] read_ofm_size;
  logic          busy, tile_done, layer_done;

  ofm_tile_addr_gen_if #(.ADDR_W(AW)) rd ();

  ofm_tile_addr_gen #(
    .SYSTOLIC_SIZE(SS), .RAM_SIZE(RAM_SIZE), .ADDR_W(AW), .CH_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .start_read_addr(start_read_addr),
    .load(load), .ifm_size(ifm_size), .ifm_channel(ifm_channel),
    .kernel_size(kernel_size), .stride(stride), .ofm_size(ofm_size),
    .rd(rd), .read_ofm_size(read_ofm_size), .busy(busy),
    .tile_done(tile_done), .layer_done(layer_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;

  int     m_s, m_c, m_k, m_st, m_o;
  longint m_base;
  longint exp_q[$];
  longint got_q[$];
  int     exp_ros, last_ros;
  bit     exp_ld;

  typedef struct {
    int     s, c, k, st, o;
    longint base;
    int     burst;
    longint first;
    int     ros;
    bit     ld;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected burst b of the layer: tiles walk columns in steps of SS,
  // rows 0..O-1 inside each tile, and the layer restarts after the last one.
  task automatic model_burst(input int b);
    int tiles, nb, bb, col, row, stv;
    tiles = (m_o + SS - 1) / SS;
    nb    = tiles * m_o;
    bb    = b % nb;
    col   = (bb / m_o) * SS;
    row   = bb % m_o;
    stv   = m_st ? 2 : 1;
    exp_q.delete();
    for (int c = 0; c < m_c; c++)
      for (int ky = 0; ky < m_k; ky++)
        for (int kx = 0; kx < m_k; kx++)
          exp_q.push_back((m_base + longint'(row * stv * m_s) + longint'(col * stv)
                           + longint'(c * m_s * m_s) + longint'(ky * m_s + kx)) & MASK);
    exp_ros = (m_o - col < SS) ? (m_o - col) : SS;
    exp_ld  = (bb == nb - 1);
  endtask

  task automatic do_start(input int s, input int c, input int k, input int st,
                          input int o, input longint base);
    m_s = s; m_c = c; m_k = k; m_st = st; m_o = o; m_base = base;
    ifm_size        = 9'(s);
    ifm_channel     = CW'(c);
    kernel_size     = 2'(k);
    stride          = 1'(st);
    ofm_size        = 9'(o);
    start_read_addr = AW'(base);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // mode 0: always ready; 1: random ready and stray loads; 2: stall 3 cycles on 2nd address.
  task automatic do_burst(input int b, input int mode, output int td_at);
    bit done, rdy;
    int stalls;
    done   = 1'b0;
    stalls = 0;
    td_at  = -1;
    model_burst(b);
    got_q.delete();
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int cyc = 1; cyc <= 3000 && !done; cyc++) begin
      if (tile_done) begin
        done     = 1'b1;
        td_at    = cyc;
        last_ros = int'(read_ofm_size);
        chk($sformatf("layer_done b%0d", b), layer_done, exp_ld);
        chk($sformatf("read_ofm_size b%0d", b), read_ofm_size, exp_ros);
      end else begin
        if (mode == 1) load = ($urandom_range(0, 7) == 0);
        if (rd.read_en) begin
          if (mode == 1) rdy = ($urandom_range(0, 3) != 0);
          else if (mode == 2 && got_q.size() == 1 && stalls < 3) begin
            rdy = 1'b0;
            stalls++;
            chk("stall_hold_addr", rd.ofm_addr, exp_q[1]);
          end else rdy = 1'b1;
          rd.addr_ready = rdy;
          if (rdy) got_q.push_back(longint'(rd.ofm_addr));
        end else begin
          rd.addr_ready = 1'b0;
        end
        tick();
      end
    end
    chk($sformatf("burst_complete b%0d", b), done, 1);
    chk($sformatf("burst_len b%0d", b), got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("addr[%0d] b%0d", i, b), (i < got_q.size()) ? got_q[i] : -1, exp_q[i]);
    if (mode == 1) load = ($urandom_range(0, 1) == 1);
    rd.addr_ready = 1'b0;
    tick();
    load = 1'b0;
    chk($sformatf("tile_done_pulse b%0d", b), tile_done, 0);
    chk($sformatf("idle_after b%0d", b), busy, 0);
  endtask

  initial begin
    int     td, k, st, s, o, c, nb;
    longint base;
    bit     any;
    longint s1[9] = '{100, 101, 102, 105, 106, 107, 110, 111, 112};
    longint s2[4] = '{0, 16, 32, 48};

    rst = 1'b1; start = 1'b0; load = 1'b0; stride = 1'b0;
    start_read_addr = '0; ifm_size = '0; ofm_size = '0;
    ifm_channel = '0; kernel_size = '0; rd.addr_ready = 1'b0;
    tick(); tick();
    chk("rst ofm_addr", rd.ofm_addr, 0);
    chk("rst read_en", rd.read_en, 0);
    chk("rst read_ofm_size", read_ofm_size, 0);
    chk("rst busy", busy, 0);
    chk("rst tile_done", tile_done, 0);
    chk("rst layer_done", layer_done, 0);
    rst = 1'b0;
    tick();

    vt[0] = '{5, 1, 3, 0, 3, 100, 0, 100, 3, 0};
    vt[1] = '{5, 1, 3, 0, 3, 100, 1, 105, 3, 0};
    vt[2] = '{5, 1, 3, 0, 3, 100, 2, 110, 3, 1};
    vt[3] = '{4, 4, 1, 0, 4, 0, 0, 0, 4, 0};
    vt[4] = '{4, 4, 1, 0, 4, 0, 1, 4, 4, 0};
    vt[5] = '{7, 1, 3, 1, 3, 0, 1, 14, 3, 0};
    vt[6] = '{7, 1, 3, 1, 3, 0, 2, 28, 3, 1};
    vt[7] = '{6, 1, 1, 0, 6, 0, 5, 30, 4, 0};
    vt[8] = '{6, 1, 1, 0, 6, 0, 6, 4, 2, 0};
    vt[9] = '{6, 1, 1, 0, 6, 0, 11, 34, 2, 1};

    for (int v = 0; v < 10; v++) begin
      do_start(vt[v].s, vt[v].c, vt[v].k, vt[v].st, vt[v].o, vt[v].base);
      for (int b = 0; b <= vt[v].burst; b++) do_burst(b, 0, td);
      chk($sformatf("vec%0d first_addr", v), (got_q.size() > 0) ? got_q[0] : -1, vt[v].first);
      chk($sformatf("vec%0d read_ofm_size", v), last_ros, vt[v].ros);
      chk($sformatf("vec%0d layer_done", v), exp_ld, vt[v].ld);
    end

    // Known full bursts and tile_done latency at full throughput.
    do_start(5, 1, 3, 0, 3, 100);
    do_burst(0, 0, td);
    chk("s1 td_latency", td, 10);
    for (int i = 0; i < 9; i++)
      chk($sformatf("s1 addr[%0d]", i), (i < got_q.size()) ? got_q[i] : -1, s1[i]);
    do_start(4, 4, 1, 0, 4, 0);
    do_burst(0, 0, td);
    for (int i = 0; i < 4; i++)
      chk($sformatf("s2 addr[%0d]", i), (i < got_q.size()) ? got_q[i] : -1, s2[i]);

    // Back-pressure on the second address.
    do_start(5, 1, 3, 0, 3, 100);
    do_burst(0, 2, td);
    chk("stall td_latency", td, 13);
    for (int i = 0; i < 9; i++)
      chk($sformatf("stall addr[%0d]", i), (i < got_q.size()) ? got_q[i] : -1, s1[i]);

    // start in the middle of a burst.
    do_start(5, 1, 3, 0, 3, 100);
    load = 1'b1; tick(); load = 1'b0;
    rd.addr_ready = 1'b1;
    tick(); tick(); tick();
    rd.addr_ready = 1'b0;
    start_read_addr = AW'(200);
    m_base = 200;
    start = 1'b1; tick(); start = 1'b0;
    chk("start busy", busy, 0);
    chk("start read_en", rd.read_en, 0);
    chk("start tile_done", tile_done, 0);
    any = 1'b0;
    repeat (5) begin any = any | tile_done; tick(); end
    chk("start no tile_done", any, 0);
    do_burst(0, 0, td);
    chk("start first_addr", (got_q.size() > 0) ? got_q[0] : -1, 200);

    // rst in the middle of a burst.
    load = 1'b1; tick(); load = 1'b0;
    rd.addr_ready = 1'b1;
    tick(); tick();
    rd.addr_ready = 1'b0;
    rst = 1'b1; tick();
    chk("midrst ofm_addr", rd.ofm_addr, 0);
    chk("midrst read_en", rd.read_en, 0);
    chk("midrst read_ofm_size", read_ofm_size, 0);
    chk("midrst busy", busy, 0);
    chk("midrst tile_done", tile_done, 0);
    chk("midrst layer_done", layer_done, 0);
    rst = 1'b0;
    any = 1'b0;
    repeat (4) begin any = any | tile_done | busy; tick(); end
    chk("midrst quiet", any, 0);

    // Randomized layers, each walked fully plus one burst into the rewind.
    for (int t = 0; t < 8; t++) begin
      k  = $urandom_range(1, 3);
      st = $urandom_range(0, 1);
      s  = $urandom_range(k, 13);
      o  = (s - k) / (st + 1) + 1;
      c  = $urandom_range(1, 3);
      if ($urandom_range(0, 3) == 0) base = (longint'(1) << AW) - longint'($urandom_range(1, 60));
      else base = longint'($urandom_range(0, 100000));
      do_start(s, c, k, st, o, base);
      nb = o * ((o + SS - 1) / SS);
      for (int b = 0; b <= nb; b++) begin
        repeat ($urandom_range(0, 2)) tick();
        do_burst(b, 1, td);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
